// File: rtl/diff_pkg.sv
// rtl/diff_pkg.sv - shared constants and types for the DIFF execute stage
//   DATA_W    : operand width
//   IDX_W     : encoded bit-index width (must hold DATA_W)
//   REG_W     : destination register index width
//   IDX_EQUAL : index code reported when operands are identical
package diff_pkg;

  localparam int DATA_W = 32;
  localparam int IDX_W  = 6;
  localparam int REG_W  = 5;

  localparam logic [IDX_W-1:0] IDX_EQUAL = IDX_W'(DATA_W);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             equal;
    logic [REG_W-1:0] rd;
  } s2_payload_t;

endpackage

// File: rtl/diff_lsb_encoder.sv
// rtl/diff_lsb_encoder.sv - combinational lowest-set-bit encoder
//   x_i     in  DATA_W  difference vector
//   idx_o   out IDX_W   position of lowest set bit, IDX_EQUAL when x_i == 0
//   equal_o out 1       x_i is all zeros
module diff_lsb_encoder
  import diff_pkg::*;
(
  input  logic [DATA_W-1:0] x_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              equal_o
);

  // Scan from the top down so the last hit, the lowest set bit, wins.
  always_comb begin
    idx_o   = IDX_EQUAL;
    equal_o = (x_i == '0);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (x_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/diff_exec_stage.sv
// rtl/diff_exec_stage.sv - two-deep pipelined execute stage for DIFF
//   clk, rst            clock, synchronous active-high reset
//   flush               synchronous pipeline kill
//   in_valid/in_ready   operand handshake; in_rs, in_rt operands, in_rd destination
//   out_valid/out_ready result handshake; out_idx, out_equal, out_rd result
//   busy                any slot occupied
//   op_count            completed result handshakes, wrapping 16-bit
module diff_exec_stage
  import diff_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  input  logic [REG_W-1:0]  in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_equal,
  output logic [REG_W-1:0]  out_rd,
  output logic              busy,
  output logic [15:0]       op_count
);

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_x_q, s1_x_d;
  logic [REG_W-1:0]  s1_rd_q, s1_rd_d;
  logic              s2_valid_q, s2_valid_d;
  s2_payload_t       s2_q, s2_d;
  logic [15:0]       op_count_q, op_count_d;

  logic              s2_adv;
  logic              s1_adv;
  logic              accept;
  logic              fire;
  logic [IDX_W-1:0]  enc_idx;
  logic              enc_equal;

  diff_lsb_encoder u_enc (
    .x_i     (s1_x_q),
    .idx_o   (enc_idx),
    .equal_o (enc_equal)
  );

  // A slot may advance when the slot ahead of it is empty or draining this
  // cycle, which lets a full pipe accept and emit in the same cycle.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv && !flush;
  assign accept   = in_valid && in_ready;
  assign fire     = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_rd_d    = s1_rd_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    op_count_d = op_count_q + {15'd0, fire};

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_d.idx   = enc_idx;
          s2_d.equal = enc_equal;
          s2_d.rd    = s1_rd_q;
        end
      end
      if (s1_adv) begin
        s1_valid_d = accept;
        if (accept) begin
          s1_x_d  = in_rs ^ in_rt;
          s1_rd_d = in_rd;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_rd_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
      op_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_rd_q    <= s1_rd_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
      op_count_q <= op_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_idx   = s2_q.idx;
  assign out_equal = s2_q.equal;
  assign out_rd    = s2_q.rd;
  assign busy      = s1_valid_q || s2_valid_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_diff_exec_stage.sv
// tb/tb_diff_exec_stage.sv - self-checking bench for diff_exec_stage
module tb_diff_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_rs = '0;
  logic [31:0] in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_idx;
  logic        out_equal;
  logic [4:0]  out_rd;
  logic        busy;
  logic [15:0] op_count;

  int total = 0;
  int bad = 0;

  diff_exec_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_equal (out_equal),
    .out_rd    (out_rd),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         idx;
    logic       equal;
    logic [4:0] rd;
  } res_t;

  // Reference: the lowest set bit of x is isolated by x & -x, and its
  // position is the log2 of that power of two.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    res_t r;
    logic [31:0] x;
    logic [31:0] low;
    x   = a ^ b;
    low = x & (~x + 32'd1);
    r.rd    = rd;
    r.equal = (a == b);
    r.idx   = (a == b) ? 32 : $clog2(low);
    return r;
  endfunction

  res_t        exp_q[$];
  logic [15:0] mcnt = '0;

  // Scoreboard: runs every cycle, independent of the directed sequences.
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      exp_q.delete();
      mcnt = '0;
    end else begin
      chk("sb_op_count", op_count, mcnt);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_emit", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_idx", out_idx, e.idx);
          chk("sb_equal", out_equal, e.equal);
          chk("sb_rd", out_rd, e.rd);
        end
        mcnt = mcnt + 16'd1;
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(in_rs, in_rt, in_rd));
    end
  end

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic [5:0]  idx;
    logic        equal;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [5:0]  held_idx;
    int          cyc;

    vecs[0] = '{32'd15,         32'd0,          5'd1,  6'd0,  1'b0};
    vecs[1] = '{32'd512,        32'd0,          5'd2,  6'd9,  1'b0};
    vecs[2] = '{32'd64,         32'd0,          5'd3,  6'd6,  1'b0};
    vecs[3] = '{32'd69,         32'd68,         5'd4,  6'd0,  1'b0};
    vecs[4] = '{32'hDEADBEEF,   32'hDEADBEEF,   5'd5,  6'd32, 1'b1};
    vecs[5] = '{32'h80000000,   32'd0,          5'd31, 6'd31, 1'b0};

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_equal", out_equal, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // Table vectors, one at a time, checking exact two-cycle latency
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_rs = vecs[i].rs;
      in_rt = vecs[i].rt;
      in_rd = vecs[i].rd;
      @(negedge clk);
      chk("vec_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("vec_lat1_out_valid", out_valid, 0);
      tick();
      @(negedge clk);
      chk("vec_out_valid", out_valid, 1);
      chk("vec_idx", out_idx, vecs[i].idx);
      chk("vec_equal", out_equal, vecs[i].equal);
      chk("vec_rd", out_rd, vecs[i].rd);
      tick();
      if (i == 3) chk("vec_op_count4", op_count, 4);
    end
    chk("vec_op_count6", op_count, 6);

    // Backpressure: three ops, out_ready low for four cycles
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_rt = '0;
    in_rd = 5'd1;
    in_rs = 32'd1 << 4;
    @(negedge clk);
    chk("bp_accept1", in_ready, 1);
    tick();
    in_rd = 5'd2;
    in_rs = 32'd1 << 5;
    @(negedge clk);
    chk("bp_accept2", in_ready, 1);
    tick();
    in_rd = 5'd3;
    in_rs = 32'd1 << 6;
    @(negedge clk);
    chk("bp_full_in_ready", in_ready, 0);
    chk("bp_stall_valid", out_valid, 1);
    chk("bp_stall_rd", out_rd, 1);
    held_idx = out_idx;
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge clk);
      chk("bp_hold_in_ready", in_ready, 0);
      chk("bp_hold_rd", out_rd, 1);
      chk("bp_hold_idx", out_idx, held_idx);
      chk("bp_hold_valid", out_valid, 1);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_passthrough_in_ready", in_ready, 1);
    chk("bp_emit1_rd", out_rd, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_emit2_rd", out_rd, 2);
    tick();
    @(negedge clk);
    chk("bp_emit3_rd", out_rd, 3);
    chk("bp_emit3_idx", out_idx, 6);
    tick();
    @(negedge clk);
    chk("bp_drained", out_valid, 0);

    // Flush with two ops in flight and a third offered
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_rs = 32'h0000_0100;
    in_rd = 5'd4;
    tick();
    in_rd = 5'd5;
    tick();
    begin
      logic [15:0] cnt_before;
      cnt_before = op_count;
      in_rd = 5'd6;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", in_ready, 0);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_busy", busy, 0);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_op_count", op_count, cnt_before);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_no_emit", out_valid, 0);
    end

    // Flush into an empty pipe must still refuse the offered beat
    in_valid = 1'b1;
    in_rd = 5'd7;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_empty_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_empty_busy", busy, 0);

    // Reset with S2 stalled
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_rs = 32'h0000_0003;
    in_rd = 5'd9;
    tick();
    in_rd = 5'd10;
    tick();
    in_valid = 1'b0;
    chk("rstmid_pre_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_idx", out_idx, 0);
    chk("rstmid_equal", out_equal, 0);
    chk("rstmid_rd", out_rd, 0);
    chk("rstmid_op_count", op_count, 0);
    chk("rstmid_in_ready", in_ready, 1);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rstmid_no_emit", out_valid, 0);
    end

    // Randomized traffic against the scoreboard
    for (int k = 0; k < 400; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_rs = $urandom();
      case ($urandom_range(0, 3))
        0: in_rt = in_rs;
        1: in_rt = in_rs ^ (32'd1 << $urandom_range(0, 31));
        default: in_rt = $urandom();
      endcase
      in_rd = 5'($urandom_range(0, 31));
      flush = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("rand_drained_busy", busy, 0);
    chk("rand_queue_empty", exp_q.size(), 0);

    // Counter wrap: stream continuously until op_count reaches 0xFFFF
    in_valid = 1'b1;
    in_rs = 32'h0000_0010;
    in_rt = '0;
    in_rd = 5'd12;
    cyc = 0;
    @(negedge clk);
    while (op_count != 16'hFFFF && cyc < 70000) begin
      @(negedge clk);
      cyc++;
    end
    chk("wrap_reached_ffff", op_count, 16'hFFFF);
    chk("wrap_fire", out_valid && out_ready, 1);
    @(negedge clk);
    chk("wrap_zero", op_count, 0);
    #1;
    in_valid = 1'b0;
    tick();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
